// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// Pure declarations: no logic, no latency.
// Not applicable: carries no handshake of its own.
package mem_arb_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Which requester owns the transaction in flight
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    // Byte-enable patterns for byte, halfword and word stores on a 32-bit bus
    localparam logic [3:0] WMASK_B = 4'b0001;
    localparam logic [3:0] WMASK_H = 4'b0011;
    localparam logic [3:0] WMASK_W = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-side signals around the arbiter.
// Wires only: no latency.
// Requests use valid/ready; responses are single-cycle pulses with no back-pressure.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_resp_data;
    logic              ifu_resp_err;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_wen;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [MASK_W-1:0] lsu_req_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_resp_data;
    logic              lsu_resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    // Arbiter side: serves the requesters and drives the memory port
    modport master (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    // Environment side: requesters and memory
    modport slave (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter producing a one-hot grant (bit 0 = IFU, bit 1 = LSU).
// Combinational, zero latency.
// No back-pressure: the caller decides when a grant is consumed.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output logic [1:0] grant
);

    // A lone requester wins; on contention the one not served last time wins
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == OWN_IFU) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time, with response timeout.
// Latency: grant, >=1 issue cycle, >=1 wait cycle, then a registered one-cycle response pulse.
// Requests stall via ready (only in IDLE); memory stalls via mem_req_ready; responses have no back-pressure.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255,   // must be >= 1
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam int              MASK_W  = DATA_W / 8;
    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state;
    owner_t           owner;
    owner_t           last_grant;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;

    rr_arb2 u_rr_arb2 (
        .req        ({bus.lsu_req_valid, bus.ifu_req_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Readies are the only combinational outputs; forced low while reset is held
    assign bus.ifu_req_ready = !reset && (state == IDLE) && grant[0];
    assign bus.lsu_req_ready = !reset && (state == IDLE) && grant[1];

    // Sequencer: grant/latch in IDLE, present in ISSUE, collect or time out in WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            owner              <= OWN_IFU;
            last_grant         <= OWN_IFU;
            cnt                <= '0;
            bus.mem_req_valid  <= 1'b0;
            bus.mem_req_addr   <= '0;
            bus.mem_req_wen    <= 1'b0;
            bus.mem_req_wdata  <= '0;
            bus.mem_req_wmask  <= '0;
            bus.ifu_resp_valid <= 1'b0;
            bus.ifu_resp_data  <= '0;
            bus.ifu_resp_err   <= 1'b0;
            bus.lsu_resp_valid <= 1'b0;
            bus.lsu_resp_data  <= '0;
            bus.lsu_resp_err   <= 1'b0;
        end else begin
            // Response outputs pulse for one cycle and otherwise rest at zero
            bus.ifu_resp_valid <= 1'b0;
            bus.ifu_resp_data  <= '0;
            bus.ifu_resp_err   <= 1'b0;
            bus.lsu_resp_valid <= 1'b0;
            bus.lsu_resp_data  <= '0;
            bus.lsu_resp_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant[1]) begin
                        bus.mem_req_addr  <= bus.lsu_req_addr;
                        bus.mem_req_wen   <= bus.lsu_req_wen;
                        bus.mem_req_wdata <= bus.lsu_req_wdata;
                        bus.mem_req_wmask <= bus.lsu_req_wmask;
                        bus.mem_req_valid <= 1'b1;
                        owner             <= OWN_LSU;
                        last_grant        <= OWN_LSU;
                        state             <= ISSUE;
                    end else if (grant[0]) begin
                        // Fetches are plain reads: no data, no byte enables
                        bus.mem_req_addr  <= bus.ifu_req_addr;
                        bus.mem_req_wen   <= 1'b0;
                        bus.mem_req_wdata <= '0;
                        bus.mem_req_wmask <= MASK_W'(0);
                        bus.mem_req_valid <= 1'b1;
                        owner             <= OWN_IFU;
                        last_grant        <= OWN_IFU;
                        state             <= ISSUE;
                    end
                end

                ISSUE: begin
                    // No timeout here: memory may stall acceptance indefinitely
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        cnt               <= '0;
                        state             <= WAIT;
                    end
                end

                WAIT: begin
                    // A response arriving on the timeout cycle still wins
                    if (bus.mem_resp_valid) begin
                        state <= IDLE;
                        if (owner == OWN_IFU) begin
                            bus.ifu_resp_valid <= 1'b1;
                            bus.ifu_resp_data  <= bus.mem_resp_data;
                        end else begin
                            bus.lsu_resp_valid <= 1'b1;
                            bus.lsu_resp_data  <= bus.mem_req_wen ? '0 : bus.mem_resp_data;
                        end
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        if (owner == OWN_IFU) begin
                            bus.ifu_resp_valid <= 1'b1;
                            bus.ifu_resp_err   <= 1'b1;
                        end else begin
                            bus.lsu_resp_valid <= 1'b1;
                            bus.lsu_resp_err   <= 1'b1;
                        end
                    end else begin
                        // Saturating: the branch above leaves WAIT before cnt could wrap
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with TIMEOUT=4.
// Inputs change 1ns after the rising edge; outputs are sampled 1-2ns after it.
// Memory and requester behaviour is scripted step by step.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.TIMEOUT(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.ifu_req_valid = 1'b0; bus.ifu_req_addr = '0;
        bus.lsu_req_valid = 1'b0; bus.lsu_req_addr = '0; bus.lsu_req_wen = 1'b0;
        bus.lsu_req_wdata = '0;   bus.lsu_req_wmask = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        #3;
        // Reset state
        chk("rst_mem_req", {bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_wmask, bus.mem_req_addr, bus.mem_req_wdata}, '0);
        chk("rst_resp", {bus.ifu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_valid, bus.lsu_resp_err}, '0);
        chk("rst_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, '0);
        tick(); tick();
        reset = 1'b0;

        // 1: IFU read, immediate accept, response in second WAIT cycle
        bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0000; bus.mem_req_ready = 1'b1;
        #1;
        chk("t1_ifu_ready", bus.ifu_req_ready, 1);
        chk("t1_lsu_ready", bus.lsu_req_ready, 0);
        tick();
        bus.ifu_req_valid = 1'b0;
        chk("t1_issue", {bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_wmask, bus.mem_req_addr}, {1'b1, 1'b0, 4'h0, 32'h8000_0000});
        tick();
        chk("t1_wait_valid", bus.mem_req_valid, 0);
        tick();
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_0413;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("t1_ifu_pulse", {bus.ifu_resp_valid, bus.ifu_resp_err, bus.ifu_resp_data}, {1'b1, 1'b0, 32'h0000_0413});
        chk("t1_lsu_quiet", bus.lsu_resp_valid, 0);
        tick();
        chk("t1_pulse_end", bus.ifu_resp_valid, 0);

        // 2: contention after reset alternates LSU, IFU, ... over 4 pairs
        reset = 1'b1; #1; reset = 1'b0;
        bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0000;
        bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_0100; bus.lsu_req_wen = 1'b0;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hCAFE_0001;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t2_lsu_grant", bus.lsu_req_ready, (i % 2 == 0));
            chk("t2_ifu_grant", bus.ifu_req_ready, (i % 2 == 1));
            tick(); tick(); tick();
            chk("t2_lsu_pulse", bus.lsu_resp_valid, (i % 2 == 0));
            chk("t2_ifu_pulse", bus.ifu_resp_valid, (i % 2 == 1));
        end
        bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        tick();

        // 3: LSU halfword store, acceptance delayed 3 cycles
        bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_1000; bus.lsu_req_wen = 1'b1;
        bus.lsu_req_wdata = 32'hDEAD_BEEF; bus.lsu_req_wmask = 4'b0011;
        #1;
        chk("t3_lsu_ready", bus.lsu_req_ready, 1);
        tick();
        bus.lsu_req_valid = 1'b0; bus.lsu_req_wen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t3_issue_stable", {bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_wmask, bus.mem_req_addr, bus.mem_req_wdata},
                {1'b1, 1'b1, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF});
            if (k == 3) bus.mem_req_ready = 1'b1;
            tick();
        end
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h1234_5678;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("t3_store_ack", {bus.lsu_resp_valid, bus.lsu_resp_err, bus.lsu_resp_data}, {1'b1, 1'b0, 32'h0});

        // 4: no response -> error after counter reaches 4; late response dropped
        bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_2000; bus.mem_req_ready = 1'b1;
        #1;
        chk("t4_lsu_ready", bus.lsu_req_ready, 1);
        tick();
        bus.lsu_req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_no_early_pulse", bus.lsu_resp_valid, 0);
        end
        tick();
        chk("t4_timeout", {bus.lsu_resp_valid, bus.lsu_resp_err, bus.lsu_resp_data}, {1'b1, 1'b1, 32'h0});
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h7777_7777;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("t4_late_dropped", {bus.lsu_resp_valid, bus.ifu_resp_valid}, 0);
        bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0040;
        #1;
        chk("t4_ifu_ready", bus.ifu_req_ready, 1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.ifu_req_valid = 1'b0;
        chk("t4_ifu_issue", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, 32'h8000_0040});
        tick();
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hABCD_0123;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("t4_ifu_resp", {bus.ifu_resp_valid, bus.ifu_resp_err, bus.ifu_resp_data}, {1'b1, 1'b0, 32'hABCD_0123});

        // 5: response on the same cycle the counter hits TIMEOUT wins
        bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_2004; bus.mem_req_ready = 1'b1;
        #1;
        tick();
        bus.lsu_req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("t5_no_pulse_yet", bus.lsu_resp_valid, 0);
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h5A5A_5A5A;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("t5_resp_wins", {bus.lsu_resp_valid, bus.lsu_resp_err, bus.lsu_resp_data}, {1'b1, 1'b0, 32'h5A5A_5A5A});

        // 6: reset mid-WAIT clears outputs at once; abandoned transaction never answers
        bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0080; bus.mem_req_ready = 1'b1;
        #1;
        tick();
        bus.ifu_req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b0;
        tick();
        reset = 1'b1; bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_3000;
        #1;
        chk("t6_async_mem_req", {bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_wmask, bus.mem_req_addr, bus.mem_req_wdata}, '0);
        chk("t6_async_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, '0);
        chk("t6_async_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, '0);
        tick(); tick();
        reset = 1'b0; bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0BAD_0BAD;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("t6_no_pulse", {bus.ifu_resp_valid, bus.lsu_resp_valid}, '0);
        bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
        #1;
        chk("t6_lsu_first", {bus.lsu_req_ready, bus.ifu_req_ready}, 2'b10);
        tick();
        bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
        chk("t6_lsu_issue", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, 32'h8000_3000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
